// File: rtl/bram.sv
// Single-port block RAM with a registered, read-first output port.
// A window of words powers up holding its own address; every other word powers up as zero.
module bram #(
    parameter int RAM_WIDTH       = 32,
    parameter int RAM_ADDR_BITS   = 9,
    parameter int INIT_START_ADDR = 0,
    parameter int INIT_END_ADDR   = 10
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     ram_enable,
    input  logic                     write_enable,
    input  logic [RAM_ADDR_BITS-1:0] address,
    input  logic [RAM_WIDTH-1:0]     input_data,
    output logic [RAM_WIDTH-1:0]     output_data
);

    localparam int DEPTH = 2 ** RAM_ADDR_BITS;

    // Power-up value of one word.
    // The address is always in [0, DEPTH-1], so the window bounds are clipped by construction.
    function automatic logic [RAM_WIDTH-1:0] init_word(input logic [RAM_ADDR_BITS-1:0] a);
        int a_int;
        a_int = int'(a);
        if (a_int >= INIT_START_ADDR && a_int <= INIT_END_ADDR)
            return RAM_WIDTH'(a);
        return '0;
    endfunction

    // The array stores each word XOR its power-up pattern.
    // An all-zero array then reads back as the pre-loaded image.
    // The pattern is a cheap function of the address and sits outside the array.
    // That keeps the array a plain zero-initialised memory, which still infers as block RAM.
    logic [RAM_WIDTH-1:0] mem [DEPTH] = '{default: '0};
    logic [RAM_WIDTH-1:0] dout_q      = '0;
    logic [RAM_WIDTH-1:0] pattern;

    assign pattern = init_word(address);

    // NOTE: the array has no reset; only the output register clears, so the tools can map it to BRAM.
    // NOTE: non-blocking assignments make the read see the pre-write word (read-first).
    always_ff @(posedge clock) begin
        if (reset) begin
            dout_q <= '0;
        end else if (ram_enable) begin
            if (write_enable)
                mem[address] <= input_data ^ pattern;
            dout_q <= mem[address] ^ pattern;
        end
    end

    assign output_data = dout_q;

endmodule

// File: tb/tb_bram.sv
// Self-checking bench for bram.
// A behavioural memory model pushes the expected output into a scoreboard when each cycle is driven.
module tb_bram;

    localparam int W  = 32;
    localparam int AB = 9;
    localparam int D  = 2 ** AB;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          ram_enable = 1'b0;
    logic          write_enable = 1'b0;
    logic [AB-1:0] address = '0;
    logic [W-1:0]  input_data = '0;
    logic [W-1:0]  output_data;

    bram #(
        .RAM_WIDTH      (W),
        .RAM_ADDR_BITS  (AB),
        .INIT_START_ADDR(0),
        .INIT_END_ADDR  (10)
    ) dut (
        .clock       (clk),
        .reset       (reset),
        .ram_enable  (ram_enable),
        .write_enable(write_enable),
        .address     (address),
        .input_data  (input_data),
        .output_data (output_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [W-1:0] val;
    } exp_t;

    exp_t         sb[$];
    logic [W-1:0] model_mem [D];
    logic [W-1:0] model_out;
    int           checks = 0;
    int           errors = 0;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One clock: the model predicts the output and pushes it, then the bench drives the inputs.
    // After the edge the bench pops the prediction and compares it with the DUT output.
    task automatic cycle(input logic rst, input logic en, input logic we,
                         input logic [AB-1:0] a, input logic [W-1:0] d, input string tag);
        exp_t e;
        if (rst) begin
            model_out = '0;
        end else if (en) begin
            model_out = model_mem[a];
            if (we) model_mem[a] = d;
        end
        sb.push_back('{tag, model_out});
        reset = rst; ram_enable = en; write_enable = we; address = a; input_data = d;
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check(e.tag, output_data, e.val);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int a = 0; a < D; a++) model_mem[a] = (a <= 10) ? W'(a) : '0;
        model_out = '0;

        #1;
        check("powerup_out", output_data, '0);

        // Power-up contents: 0..10 hold their address, 11..19 hold zero.
        for (int a = 0; a < 20; a++) cycle(0, 1, 0, AB'(a), '0, $sformatf("init_rd%0d", a));
        check("init_last_zero", output_data, '0);

        // Enable gating: a write with the port disabled does nothing and the output holds.
        cycle(0, 1, 0, 9, '0, "gate_pre_rd9");
        cycle(0, 0, 1, 5, 32'hDEAD, "gate_hold");
        check("gate_hold_const", output_data, 32'd9);
        cycle(0, 1, 0, 5, '0, "gate_rd5");
        check("gate_rd5_const", output_data, 32'd5);

        // Reset clears the output only and blocks a same-cycle write.
        cycle(0, 1, 0, 7, '0, "rst_pre_rd7");
        cycle(1, 1, 1, 7, 32'hFFFF, "rst_out_zero");
        check("rst_zero_const", output_data, '0);
        cycle(0, 1, 0, 7, '0, "rst_post_rd7");
        check("rst_mem_kept", output_data, 32'd7);

        // Writes show the pre-write word, then a readback returns the new words.
        for (int k = 0; k < 20; k++) cycle(0, 1, 1, AB'(k), W'(k * 10), $sformatf("wr%0d_old", k));
        for (int k = 0; k < 20; k++) cycle(0, 1, 0, AB'(k), '0, $sformatf("rb%0d", k));
        check("rb19_const", output_data, 32'd190);

        // Address boundaries: both ends of the array, and the untouched word next to the top.
        cycle(0, 1, 1, 511, 32'hA5A5A5A5, "wr511_old");
        cycle(0, 1, 1, 0, 32'hA5A5A5A5, "wr0_old");
        cycle(0, 1, 0, 511, '0, "rd511");
        check("rd511_const", output_data, 32'hA5A5A5A5);
        cycle(0, 1, 0, 0, '0, "rd0");
        check("rd0_const", output_data, 32'hA5A5A5A5);
        cycle(0, 1, 0, 510, '0, "rd510");
        check("rd510_const", output_data, '0);

        // A random mix of reads and writes against the model.
        for (int i = 0; i < 200; i++)
            cycle(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0), $urandom_range(0, 1),
                  AB'($urandom_range(0, D - 1)), $urandom, $sformatf("rand%0d", i));

        if (sb.size() != 0) check("sb_empty", W'(sb.size()), '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
